// File: rtl/iram_controller.sv
// Instruction-miss responder: fetches one cache line from the synchronous instruction ROM
// word by word, packs it into imem_word and pulses word_ready when the line is complete.
module iram_controller #(
  parameter int PC_SIZE     = 32,
  parameter int WORD_W      = 32,
  parameter int LINE_WORDS  = 4,
  parameter int ROM_ADDR_W  = 10,
  parameter int ROM_LATENCY = 2
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         i_miss,
  input  logic [PC_SIZE-1:0]           iram_address,
  output logic [LINE_WORDS*WORD_W-1:0] imem_word,
  output logic                         word_ready,
  output logic                         busy,
  output logic                         rom_re,
  output logic [ROM_ADDR_W-1:0]        rom_addr,
  input  logic [WORD_W-1:0]            rom_data
);

  localparam int BYTE_SH = $clog2(WORD_W / 8);
  localparam int WCNT_W  = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int LCNT_W  = $clog2(ROM_LATENCY + 1);
  localparam logic [ROM_ADDR_W-1:0] LINE_MASK  = ~ROM_ADDR_W'(LINE_WORDS - 1);
  localparam logic [WCNT_W-1:0]     WCNT_LAST  = WCNT_W'(LINE_WORDS - 1);
  localparam logic [LCNT_W-1:0]     LCNT_LAST  = LCNT_W'(ROM_LATENCY);

  // CAPT is kept in the encoding but the capture happens in the last WAIT cycle.
  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_CAPT, S_DONE, S_HOLD
  } state_e;

  state_e                         state_q, state_d;
  logic [ROM_ADDR_W-1:0]          line_q, line_d;
  logic [WCNT_W-1:0]              wcnt_q, wcnt_d;
  logic [LCNT_W-1:0]              lcnt_q, lcnt_d;
  logic [ROM_ADDR_W-1:0]          addr_q, addr_d;
  logic [LINE_WORDS*WORD_W-1:0]   data_q, data_d;
  logic [ROM_ADDR_W-1:0]          miss_base;
  logic [ROM_ADDR_W-1:0]          req_addr;

  // Addresses beyond the ROM wrap silently through the truncating cast.
  assign miss_base = ROM_ADDR_W'(iram_address >> BYTE_SH) & LINE_MASK;
  assign req_addr  = line_q + ROM_ADDR_W'(wcnt_q);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      line_q  <= '0;
      wcnt_q  <= '0;
      lcnt_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      wcnt_q  <= wcnt_d;
      lcnt_q  <= lcnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    wcnt_d  = wcnt_q;
    lcnt_d  = lcnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (i_miss) begin
          line_d  = miss_base;
          wcnt_d  = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        addr_d  = req_addr;
        lcnt_d  = LCNT_W'(1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (lcnt_q == LCNT_LAST) begin
          data_d[wcnt_q*WORD_W +: WORD_W] = rom_data;
          if (wcnt_q == WCNT_LAST) begin
            state_d = S_DONE;
          end else begin
            wcnt_d  = wcnt_q + 1'b1;
            state_d = S_REQ;
          end
        end else begin
          lcnt_d = lcnt_q + 1'b1;
        end
      end
      S_DONE: state_d = S_HOLD;
      // The core may still be dropping i_miss; never restart until it is seen low.
      S_HOLD: begin
        if (!i_miss) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rom_re     = (state_q == S_REQ);
    rom_addr   = rom_re ? req_addr : addr_q;
    word_ready = (state_q == S_DONE);
    busy       = (state_q != S_IDLE);
    imem_word  = data_q;
  end

endmodule

// File: tb/tb_iram_controller.sv
// Scoreboard bench for iram_controller: expected ROM reads and refilled lines are queued
// when a miss is driven and compared when the controller produces them.
module tb_iram_controller;

  logic         clk = 1'b0;
  logic         nrst;
  logic         i_miss;
  logic [31:0]  iram_address;
  logic [127:0] imem_word;
  logic         word_ready;
  logic         busy;
  logic         rom_re;
  logic [9:0]   rom_addr;
  logic [31:0]  rom_data;

  iram_controller dut (
    .clk          (clk),
    .nrst         (nrst),
    .i_miss       (i_miss),
    .iram_address (iram_address),
    .imem_word    (imem_word),
    .word_ready   (word_ready),
    .busy         (busy),
    .rom_re       (rom_re),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data)
  );

  always #5 clk = ~clk;

  // Two-cycle synchronous ROM; word n holds 0xA000_0000 + n.
  logic [31:0] rom_p1;
  always @(posedge clk) begin
    rom_p1   <= rom_re ? (32'hA000_0000 + 32'(rom_addr)) : 32'hDEAD_BEEF;
    rom_data <= rom_p1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [9:0] addr; } re_t;
  typedef struct { int cyc; logic [127:0] line; } line_t;
  re_t   re_q[$];
  line_t ln_q[$];

  int n_checks = 0;
  int n_errors = 0;
  logic [127:0] last_line = '0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives a miss in the current cycle (cycle 0) and queues the expected reads and line.
  task automatic start_miss(input logic [31:0] a);
    logic [9:0]   base;
    logic [127:0] line;
    int t0;
    @(negedge clk);
    iram_address = a;
    i_miss       = 1'b1;
    t0           = cyc;
    base         = 10'(a >> 2) & 10'h3FC;
    line         = '0;
    for (int k = 0; k < 4; k++) begin
      re_t r;
      r.cyc  = t0 + 1 + k * 3;
      r.addr = 10'(base + 10'(k));
      re_q.push_back(r);
      line[k*32 +: 32] = 32'hA000_0000 + 32'(r.addr);
    end
    begin
      line_t l;
      l.cyc  = t0 + 13;
      l.line = line;
      ln_q.push_back(l);
    end
    last_line = line;
  endtask

  logic wr_prev = 1'b0;
  always @(negedge clk) begin
    if (nrst) begin
      if (rom_re) begin
        check("re_pending", 128'(re_q.size() > 0), 128'(1));
        if (re_q.size() > 0) begin
          re_t e;
          e = re_q.pop_front();
          check("re_cycle", 128'(cyc), 128'(e.cyc));
          check("re_addr", 128'(rom_addr), 128'(e.addr));
        end
      end else if (re_q.size() > 0 && re_q[0].cyc <= cyc) begin
        check("re_missing", 128'(rom_re), 128'(1));
        void'(re_q.pop_front());
      end
      if (word_ready) begin
        check("wr_single", 128'(wr_prev), 128'(0));
        check("wr_pending", 128'(ln_q.size() > 0), 128'(1));
        if (ln_q.size() > 0) begin
          line_t l;
          l = ln_q.pop_front();
          check("wr_cycle", 128'(cyc), 128'(l.cyc));
          check("wr_line", imem_word, l.line);
        end
      end else if (ln_q.size() > 0 && ln_q[0].cyc <= cyc) begin
        check("wr_missing", 128'(word_ready), 128'(1));
        void'(ln_q.pop_front());
      end
    end
    wr_prev = word_ready;
  end

  initial begin
    nrst         = 1'b0;
    i_miss       = 1'b0;
    iram_address = '0;
    #1;
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_re", 128'(rom_re), 128'(0));
    check("rst_wr", 128'(word_ready), 128'(0));
    check("rst_addr", 128'(rom_addr), 128'(0));
    check("rst_line", imem_word, 128'(0));
    wait_cycles(3);
    nrst = 1'b1;
    wait_cycles(2);

    // Basic refill
    start_miss(32'h104);
    wait_cycles(13);
    i_miss = 1'b0;
    wait_cycles(2);
    check("basic_idle", 128'(busy), 128'(0));
    check("basic_hold_line", imem_word, 128'h A0000043_A0000042_A0000041_A0000040);

    // Early release, with an address change after latching
    start_miss(32'h200);
    wait_cycles(2);
    iram_address = 32'h300;
    wait_cycles(3);
    i_miss = 1'b0;
    wait_cycles(9);
    check("early_hold_busy", 128'(busy), 128'(1));
    wait_cycles(1);
    check("early_idle", 128'(busy), 128'(0));

    // Miss held past word_ready stays in HOLD, then a new refill follows
    start_miss(32'h40);
    wait_cycles(16);
    check("held_busy", 128'(busy), 128'(1));
    check("held_no_re", 128'(rom_re), 128'(0));
    i_miss = 1'b0;
    wait_cycles(1);
    check("held_idle", 128'(busy), 128'(0));
    start_miss(32'h400);
    wait_cycles(13);
    i_miss = 1'b0;
    wait_cycles(3);
    check("line_kept", imem_word, last_line);

    // Reset in the middle of a refill
    start_miss(32'h104);
    wait_cycles(6);
    #2;
    nrst = 1'b0;
    #1;
    check("midrst_re", 128'(rom_re), 128'(0));
    check("midrst_busy", 128'(busy), 128'(0));
    check("midrst_line", imem_word, 128'(0));
    re_q.delete();
    ln_q.delete();
    i_miss = 1'b0;
    wait_cycles(2);
    nrst = 1'b1;
    wait_cycles(1);
    start_miss(32'h104);
    wait_cycles(13);
    i_miss = 1'b0;
    wait_cycles(3);

    // ROM address wrap
    start_miss(32'hFFC);
    wait_cycles(13);
    i_miss = 1'b0;
    wait_cycles(3);
    start_miss(32'h1000);
    wait_cycles(13);
    i_miss = 1'b0;
    wait_cycles(3);
    check("wrap_line", imem_word, 128'h A0000003_A0000002_A0000001_A0000000);

    wait_cycles(2);
    check("re_q_drained", 128'(re_q.size()), 128'(0));
    check("ln_q_drained", 128'(ln_q.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
